// File: rtl/mips_processor_top.sv
// mips_processor_top: single-cycle word-addressed 32-bit MIPS-style core with host-loaded memories.
//   clk, rst (async active-low); instr/instr_addr/ins_we load instruction memory;
//   data/data_addr/data_we load data memory; processor_out = last write-back value; done = sticky halt.
module mips_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] RF [0:31];
   always_ff @(posedge clk or negedge rst)
      if (!rst) for (int i = 0; i < 32; i++) RF[i] <= '0;
      else if (we && wa != 5'd0) RF[wa] <= wd;
   assign rd1 = (ra1 == 5'd0) ? '0 : RF[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : RF[ra2];
endmodule

module mips_data_mem (
   input  logic        clk,
   input  logic        we,
   input  logic [9:0]  wa,
   input  logic [31:0] wd,
   input  logic [9:0]  ra,
   output logic [31:0] rd
);
   logic [31:0] mem [0:1023];
   always_ff @(posedge clk)
      if (we) mem[wa] <= wd;
   assign rd = mem[ra];
endmodule

module mips_processor_top (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic [9:0]  instr_addr,
   input  logic        ins_we,
   input  logic [31:0] data,
   input  logic [9:0]  data_addr,
   input  logic        data_we,
   output logic [31:0] processor_out,
   output logic        done
);
   logic [31:0] imem [0:1023];
   logic [9:0]  pc_q, pc_d, PC_out, mem_addr;
   logic        done_q, done_d, run, rf_we, sw_we;
   logic [31:0] out_q, out_d, ins_out, a, b, wb, sext, zext, dm_rd;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt, wa;
   logic [15:0] imm;
   always_ff @(posedge clk)
      if (ins_we) imem[instr_addr] <= instr;
   assign PC_out  = pc_q;
   assign ins_out = imem[pc_q];
   assign op    = ins_out[31:26];
   assign rs    = ins_out[25:21];
   assign rt    = ins_out[20:16];
   assign rd    = ins_out[15:11];
   assign shamt = ins_out[10:6];
   assign funct = ins_out[5:0];
   assign imm   = ins_out[15:0];
   assign sext  = {{16{imm[15]}}, imm};
   assign zext  = {16'b0, imm};
   // only the low 10 bits of rs+sext address memory, so a 10-bit add suffices
   assign mem_addr = a[9:0] + imm[9:0];
   // host loads stall the core, so they never race a core store
   assign run = rst && !done_q && !ins_we && !data_we;
   mips_regfile regs (
      .clk(clk), .rst(rst), .we(rf_we), .wa(wa), .wd(wb),
      .ra1(rs), .ra2(rt), .rd1(a), .rd2(b)
   );
   mips_data_mem data_mem (
      .clk(clk), .we(data_we || sw_we), .wa(data_we ? data_addr : mem_addr),
      .wd(data_we ? data : b), .ra(mem_addr), .rd(dm_rd)
   );
   always_comb begin
      wb     = '0;
      rf_we  = 1'b0;
      sw_we  = 1'b0;
      wa     = rt;
      pc_d   = pc_q + 10'd1;
      done_d = done_q;
      case (op)
         6'b000000: begin
            wa    = rd;
            rf_we = 1'b1;
            case (funct)
               6'b000000, 6'b000001: wb = a + b;
               6'b000010, 6'b000011: wb = a - b;
               6'b000100: wb = a & b;
               6'b000101: wb = a | b;
               6'b000110: wb = ~(a | b);
               6'b000111: wb = a ^ b;
               6'b001000: wb = b << shamt;
               6'b001001: wb = b >> shamt;
               6'b001010: wb = $signed(b) >>> shamt;
               6'b001011: wb = {31'b0, $signed(a) < $signed(b)};
               6'b001100: wb = a * b;
               default:   rf_we = 1'b0;
            endcase
         end
         6'b000001: begin rf_we = 1'b1; wb = a + sext; end
         6'b000011: begin rf_we = 1'b1; wb = a & zext; end
         6'b000100: begin rf_we = 1'b1; wb = a | zext; end
         6'b000101: begin rf_we = 1'b1; wb = a ^ zext; end
         6'b000110: begin rf_we = 1'b1; wb = {imm, 16'b0}; end
         6'b000111: begin rf_we = 1'b1; wb = {31'b0, $signed(a) < $signed(sext)}; end
         6'b001001: begin rf_we = 1'b1; wb = dm_rd; end
         6'b001010: sw_we = 1'b1;
         6'b001011: pc_d = (a == b) ? pc_q + 10'd1 + imm[9:0] : pc_d;
         6'b001100: pc_d = (a != b) ? pc_q + 10'd1 + imm[9:0] : pc_d;
         6'b001110: pc_d = ins_out[9:0];
         6'b111111: begin done_d = 1'b1; pc_d = pc_q; end
         default: ;
      endcase
      if (!run) begin
         pc_d   = pc_q;
         rf_we  = 1'b0;
         sw_we  = 1'b0;
         done_d = done_q;
      end
      out_d = rf_we ? wb : out_q;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         pc_q   <= '0;
         done_q <= 1'b0;
         out_q  <= '0;
      end else begin
         pc_q   <= pc_d;
         done_q <= done_d;
         out_q  <= out_d;
      end
   assign processor_out = out_q;
   assign done          = done_q;
endmodule

// File: tb/tb_mips_processor_top.sv
// tb_mips_processor_top: directed program checks of mips_processor_top.
module tb_mips_processor_top;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instr = '0;
   logic [9:0]  instr_addr = '0;
   logic        ins_we = 1'b0;
   logic [31:0] data = '0;
   logic [9:0]  data_addr = '0;
   logic        data_we = 1'b0;
   logic [31:0] processor_out;
   logic        done;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] prog [0:27];

   mips_processor_top dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_addr(instr_addr), .ins_we(ins_we),
      .data(data), .data_addr(data_addr), .data_we(data_we),
      .processor_out(processor_out), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] d, input logic [4:0] s,
                                        input logic [4:0] t, input logic [4:0] sh);
      return {6'b0, s, t, d, sh, fn};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] t, input logic [4:0] s,
                                        input logic [15:0] imm);
      return {op, s, t, imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_instr(input logic [9:0] addr, input logic [31:0] w);
      instr = w;
      instr_addr = addr;
      ins_we = 1'b1;
      step(1);
      ins_we = 1'b0;
   endtask

   initial begin
      prog[0]  = i_op(6'b000001, 5'd1, 5'd0, 16'd10);
      prog[1]  = i_op(6'b000001, 5'd2, 5'd0, 16'd20);
      prog[2]  = r_op(6'b000000, 5'd3, 5'd1, 5'd2, 5'd0);
      prog[3]  = i_op(6'b000001, 5'd4, 5'd3, 16'd5);
      prog[4]  = r_op(6'b000010, 5'd5, 5'd3, 5'd1, 5'd0);
      prog[5]  = r_op(6'b001100, 5'd6, 5'd1, 5'd2, 5'd0);
      prog[6]  = r_op(6'b000100, 5'd7, 5'd1, 5'd3, 5'd0);
      prog[7]  = r_op(6'b000101, 5'd8, 5'd1, 5'd3, 5'd0);
      prog[8]  = r_op(6'b000111, 5'd9, 5'd1, 5'd3, 5'd0);
      prog[9]  = i_op(6'b000111, 5'd10, 5'd1, 16'd15);
      prog[10] = i_op(6'b000110, 5'd12, 5'd0, 16'h00FF);
      prog[11] = i_op(6'b001011, 5'd2, 5'd1, 16'd2);
      prog[12] = i_op(6'b001100, 5'd2, 5'd1, 16'd2);
      prog[13] = i_op(6'b000001, 5'd13, 5'd0, 16'd7);
      prog[14] = i_op(6'b000001, 5'd14, 5'd0, 16'd7);
      prog[15] = i_op(6'b001010, 5'd3, 5'd0, 16'd0);
      prog[16] = i_op(6'b001001, 5'd11, 5'd0, 16'd0);
      prog[17] = i_op(6'b000001, 5'd0, 5'd0, 16'd5);
      prog[18] = i_op(6'b000001, 5'd17, 5'd0, 16'hFFF8);
      prog[19] = r_op(6'b001000, 5'd15, 5'd0, 5'd1, 5'd2);
      prog[20] = r_op(6'b001010, 5'd16, 5'd0, 5'd17, 5'd1);
      prog[21] = r_op(6'b001001, 5'd18, 5'd0, 5'd17, 5'd28);
      prog[22] = r_op(6'b000110, 5'd19, 5'd1, 5'd0, 5'd0);
      prog[23] = r_op(6'b001011, 5'd20, 5'd17, 5'd1, 5'd0);
      prog[24] = {6'b001110, 16'b0, 10'd27};
      prog[25] = i_op(6'b000001, 5'd21, 5'd0, 16'd1);
      prog[26] = i_op(6'b000001, 5'd21, 5'd0, 16'd1);
      prog[27] = {6'b111111, 26'b0};

      step(1);
      for (int i = 0; i < 28; i++) load_instr(10'(i), prog[i]);
      data = 32'd42;
      data_addr = 10'd100;
      data_we = 1'b1;
      step(1);
      data_we = 1'b0;
      check("reset_pc", 32'(dut.PC_out), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_out", processor_out, 32'd0);
      check("reset_rf1", dut.regs.RF[1], 32'd0);

      rst = 1'b1;
      step(5);
      check("pc_after5", 32'(dut.PC_out), 32'd5);
      check("r1", dut.regs.RF[1], 32'd10);
      check("r3_add", dut.regs.RF[3], 32'd30);
      check("r4_addi", dut.regs.RF[4], 32'd35);
      check("r5_sub", dut.regs.RF[5], 32'd20);
      check("out_sub", processor_out, 32'd20);

      instr = 32'd0;
      instr_addr = 10'd1000;
      ins_we = 1'b1;
      step(3);
      check("stall_pc", 32'(dut.PC_out), 32'd5);
      check("stall_r6", dut.regs.RF[6], 32'd0);
      ins_we = 1'b0;

      step(8);
      check("bne_pc", 32'(dut.PC_out), 32'd15);
      check("r6_mul", dut.regs.RF[6], 32'd200);
      check("r7_and", dut.regs.RF[7], 32'd10);
      check("r8_or", dut.regs.RF[8], 32'd30);
      check("r9_xor", dut.regs.RF[9], 32'd20);
      check("r10_slti", dut.regs.RF[10], 32'd1);
      check("r12_lui", dut.regs.RF[12], 32'h00FF0000);
      check("r13_skip", dut.regs.RF[13], 32'd0);
      check("r14_skip", dut.regs.RF[14], 32'd0);

      step(2);
      check("mem0_sw", dut.data_mem.mem[0], 32'd30);
      check("r11_lw", dut.regs.RF[11], 32'd30);
      check("out_lw", processor_out, 32'd30);
      check("mem100", dut.data_mem.mem[100], 32'd42);

      step(1);
      check("r0_zero", dut.regs.RF[0], 32'd0);
      check("out_r0wr", processor_out, 32'd5);

      step(12);
      check("r15_sll", dut.regs.RF[15], 32'd40);
      check("r16_sra", dut.regs.RF[16], 32'hFFFFFFFC);
      check("r18_srl", dut.regs.RF[18], 32'h0000000F);
      check("r19_nor", dut.regs.RF[19], 32'hFFFFFFF5);
      check("r20_slt", dut.regs.RF[20], 32'd1);
      check("r21_jskip", dut.regs.RF[21], 32'd0);
      check("halt_done", 32'(done), 32'd1);
      check("halt_pc", 32'(dut.PC_out), 32'd27);
      check("halt_out", processor_out, 32'd1);

      rst = 1'b0;
      #1;
      check("rst2_pc", 32'(dut.PC_out), 32'd0);
      check("rst2_done", 32'(done), 32'd0);
      check("rst2_out", processor_out, 32'd0);
      check("rst2_rf3", dut.regs.RF[3], 32'd0);
      check("rst2_mem0", dut.data_mem.mem[0], 32'd30);
      check("rst2_mem100", dut.data_mem.mem[100], 32'd42);
      load_instr(10'd4, {6'b111111, 26'b0});
      rst = 1'b1;

      step(4);
      check("p2_pc4", 32'(dut.PC_out), 32'd4);
      check("p2_r4", dut.regs.RF[4], 32'd35);
      check("p2_notdone", 32'(done), 32'd0);
      step(1);
      check("p2_done", 32'(done), 32'd1);
      check("p2_pc_hold", 32'(dut.PC_out), 32'd4);
      step(3);
      check("p2_done_sticky", 32'(done), 32'd1);
      check("p2_pc_frozen", 32'(dut.PC_out), 32'd4);
      check("p2_r5_frozen", dut.regs.RF[5], 32'd0);
      check("p2_out", processor_out, 32'd35);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
